alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//   Shares one combinational alu instance between NREQ requesters (e.g. main pipe, AGU, debug port).
//   Picks one request round-robin, registers its operands, lets the alu evaluate for one cycle,
//   then registers alu_result/br_taken and returns them with the requester's tag.
//   Sits between the issue logic and the alu; the alu's alucode/op1/op2/alu_result/br_taken connect to the alu_* ports.
// PARAMETERS
//   NREQ   2   number of requesters (2..4)
//   TAG_W  4   width of the per-request tag, returned unchanged with the response
// PORTS
//   clk            in   1           clock, rising edge
//   rst_n          in   1           asynchronous active-low reset
//   req_valid      in   NREQ        request valid, one bit per requester
//   req_ready      out  NREQ        request accepted this cycle (one-hot or zero)
//   req_alucode    in   6*NREQ      `ALU_* code; requester i uses bits [6i+5:6i]
//   req_op1        in   32*NREQ     operand 1, slice i
//   req_op2        in   32*NREQ     operand 2, slice i
//   req_tag        in   TAG_W*NREQ  tag, slice i
//   rsp_valid      out  NREQ        response valid for the granted requester (one-hot or zero)
//   rsp_ready      in   NREQ        response consumed
//   rsp_result     out  32          registered alu_result
//   rsp_br_taken   out  1           registered br_taken (`ENABLE/`DISABLE)
//   rsp_tag        out  TAG_W       tag of the granted request
//   alu_alucode    out  6           to alu alucode
//   alu_op1        out  32          to alu op1
//   alu_op2        out  32          to alu op2
//   alu_result     in   32          from alu
//   alu_br_taken   in   1           from alu
//   stat_grants    out  16*NREQ     per-requester grant count (see CONFIGURATION)
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; req_ready=0, rsp_valid=0, rsp_result=0, rsp_br_taken=`DISABLE,
//     rsp_tag=0, alu_alucode/alu_op1/alu_op2=0 (operand regs), rr pointer=NREQ-1 (requester 0 wins first), stat_grants=0.
//   FSM: IDLE -> EXEC -> RESP -> IDLE.
//   IDLE: if any req_valid, grant g = first valid index after rr pointer (wrapping modulo NREQ); req_ready[g]=1
//     combinationally in the same cycle; on the clock edge latch alucode/op1/op2/tag of g, set pointer=g, go EXEC.
//     req_ready is 0 in every other state and for every non-granted index.
//   EXEC: operand regs drive alu_*; at the clock edge capture alu_result->rsp_result and alu_br_taken->rsp_br_taken; go RESP.
//   RESP: rsp_valid[g]=1, rsp_result/rsp_br_taken/rsp_tag stable; leave when rsp_ready[g]=1, back to IDLE
//     (rsp_valid drops the next cycle). rsp_ready bits of other requesters are ignored.
//   Latency: accept in cycle N -> rsp_valid in cycle N+2. Throughput: at most one op per 3 cycles.
//   Operand regs hold their last value outside IDLE->EXEC; the alu is never driven straight from req_* ports.
//   Simultaneous requests: strict round robin; a requester that keeps req_valid high is served within NREQ grants.
//   Requester drops req_valid while not granted: no effect. Unrecognised alucode is passed through;
//     its rsp_result is unspecified (the alu holds its value), rsp_br_taken likewise; the FSM still completes normally.
//   Reset mid-operation: in-flight op is discarded, no response is issued, and all state returns to its reset values.
// CONFIGURATION
//   ALU_ARB_STATS_EN defined: stat_grants slice i = 16-bit grant counter for requester i, incremented on each
//     req_ready[i] handshake, saturates at 16'hFFFF, cleared only by reset.
//   Not defined: no counters are built; stat_grants is tied to 0. All other behaviour is identical.
// TESTING
//   1 Single op: req0 ADD op1=5 op2=7 tag=3 -> req_ready[0] in the accept cycle; 2 cycles later rsp_valid=01,
//     rsp_result=12, rsp_br_taken=`DISABLE, rsp_tag=3.
//   2 Branch: req1 BEQ op1=op2=32'h10 -> rsp_br_taken=`ENABLE, rsp_result=0; BNE with same operands -> `DISABLE.
//   3 Contention: req0 and req1 both held valid for 4 ops after reset -> grant order 0,1,0,1, each tag returned correctly.
//   4 Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_result stay stable; req_ready stays 0 for every
//     requester; the next grant comes only after the handshake.
//   5 Reset in EXEC: assert rst_n=0 asynchronously -> rsp_valid=0 immediately; after release, req1 alone is granted,
//     and with both valid requester 0 is granted first.
//   6 With ALU_ARB_STATS_EN: 3 grants to req0 and 1 to req1 -> stat_grants={16'd1,16'd3}; without the macro -> 0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one combinational alu between NREQ requesters.
// Optional per-requester grant counters are built when ALU_ARB_STATS_EN is defined.
module alu_share_arbiter #(
  parameter int NREQ  = 2,
  parameter int TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [6*NREQ-1:0]     req_alucode,
  input  logic [32*NREQ-1:0]    req_op1,
  input  logic [32*NREQ-1:0]    req_op2,
  input  logic [TAG_W*NREQ-1:0] req_tag,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [31:0]           rsp_result,
  output logic                  rsp_br_taken,
  output logic [TAG_W-1:0]      rsp_tag,
  output logic [5:0]            alu_alucode,
  output logic [31:0]           alu_op1,
  output logic [31:0]           alu_op2,
  input  logic [31:0]           alu_result,
  input  logic                  alu_br_taken,
  output logic [16*NREQ-1:0]    stat_grants
);

  localparam int   IDX_W      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic BR_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  // rr_ptr doubles as the index of the request currently in flight.
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_any;

  logic [5:0]       alucode_q;
  logic [31:0]      op1_q;
  logic [31:0]      op2_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      result_q;
  logic             br_q;

  logic [5:0]       code_arr [NREQ];
  logic [31:0]      op1_arr  [NREQ];
  logic [31:0]      op2_arr  [NREQ];
  logic [TAG_W-1:0] tag_arr  [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign code_arr[i] = req_alucode[6*i +: 6];
    assign op1_arr[i]  = req_op1[32*i +: 32];
    assign op2_arr[i]  = req_op2[32*i +: 32];
    assign tag_arr[i]  = req_tag[TAG_W*i +: TAG_W];
  end

  // Search starts one past the last grant, so the last winner has lowest priority.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first; otherwise a missed path infers a latch.
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      logic [IDX_W-1:0] cand;
      cand = IDX_W'((int'(rr_ptr) + k) % NREQ);
      if (!grant_any && req_valid[cand]) begin
        grant_idx = cand;
        grant_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready[rr_ptr]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state == IDLE && grant_any) req_ready[grant_idx] = 1'b1;
    if (state == RESP)              rsp_valid[rr_ptr]    = 1'b1;
  end

  // The alu only ever sees registered operands, never the req_* ports directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= IDX_W'(NREQ - 1);
      alucode_q <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      tag_q     <= '0;
      result_q  <= '0;
      br_q      <= BR_DISABLE;
    end else begin
      if (state == IDLE && grant_any) begin
        rr_ptr    <= grant_idx;
        alucode_q <= code_arr[grant_idx];
        op1_q     <= op1_arr[grant_idx];
        op2_q     <= op2_arr[grant_idx];
        tag_q     <= tag_arr[grant_idx];
      end
      if (state == EXEC) begin
        result_q <= alu_result;
        br_q     <= alu_br_taken;
      end
    end
  end

  assign alu_alucode  = alucode_q;
  assign alu_op1      = op1_q;
  assign alu_op2      = op2_q;
  assign rsp_result   = result_q;
  assign rsp_br_taken = br_q;
  assign rsp_tag      = tag_q;

`ifdef ALU_ARB_STATS_EN
  for (genvar i = 0; i < NREQ; i++) begin : g_stats
    logic [15:0] grant_cnt;

    // Saturating so a long-running count never wraps back to a misleading small value.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        grant_cnt <= '0;
      end else if (req_ready[i] && grant_cnt != 16'hFFFF) begin
        grant_cnt <= grant_cnt + 16'd1;
      end
    end

    assign stat_grants[16*i +: 16] = grant_cnt;
  end
`else
  assign stat_grants = '0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed, table-driven bench for alu_share_arbiter with a small behavioural alu attached.
// Stats expectations follow whether ALU_ARB_STATS_EN is defined for the build.
module tb_alu_share_arbiter;

  localparam int NREQ  = 2;
  localparam int TAG_W = 4;

  localparam logic [5:0] ALU_ADD = 6'd1;
  localparam logic [5:0] ALU_SUB = 6'd2;
  localparam logic [5:0] ALU_AND = 6'd3;
  localparam logic [5:0] ALU_BEQ = 6'd16;
  localparam logic [5:0] ALU_BNE = 6'd17;
  localparam logic [5:0] ALU_BAD = 6'd63;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [6*NREQ-1:0]     req_alucode;
  logic [32*NREQ-1:0]    req_op1;
  logic [32*NREQ-1:0]    req_op2;
  logic [TAG_W*NREQ-1:0] req_tag;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [31:0]           rsp_result;
  logic                  rsp_br_taken;
  logic [TAG_W-1:0]      rsp_tag;
  logic [5:0]            alu_alucode;
  logic [31:0]           alu_op1;
  logic [31:0]           alu_op2;
  logic [31:0]           alu_result;
  logic                  alu_br_taken;
  logic [16*NREQ-1:0]    stat_grants;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NREQ(NREQ), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_alucode(req_alucode), .req_op1(req_op1), .req_op2(req_op2), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_br_taken(rsp_br_taken), .rsp_tag(rsp_tag),
    .alu_alucode(alu_alucode), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_result(alu_result), .alu_br_taken(alu_br_taken),
    .stat_grants(stat_grants)
  );

  // Stand-in for the shared alu.
  always_comb begin
    alu_result   = 32'h0;
    alu_br_taken = 1'b0;
    case (alu_alucode)
      ALU_ADD: alu_result = alu_op1 + alu_op2;
      ALU_SUB: alu_result = alu_op1 - alu_op2;
      ALU_AND: alu_result = alu_op1 & alu_op2;
      ALU_BEQ: alu_br_taken = (alu_op1 == alu_op2);
      ALU_BNE: alu_br_taken = (alu_op1 != alu_op2);
      default: alu_result = 32'hBAD0_BAD0;
    endcase
  end

  typedef struct {
    logic [1:0]  vmask;
    int          req;
    logic [5:0]  code;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  tag;
    logic [31:0] exp_res;
    logic        exp_br;
    bit          chk;
    int          stall;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic set_req(input int i, input logic [5:0] code, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] t);
    req_alucode[6*i +: 6]       = code;
    req_op1[32*i +: 32]         = a;
    req_op2[32*i +: 32]         = b;
    req_tag[TAG_W*i +: TAG_W]   = t;
  endtask

  // One full accept -> exec -> resp transaction; req_valid stays at vmask afterwards.
  task automatic do_txn(input string nm, input logic [1:0] vmask, input int g,
                        input logic [31:0] exp_res, input logic exp_br, input logic [3:0] exp_tag,
                        input bit chk, input int stall);
    logic [1:0] oh;
    oh = 2'(1 << g);
    @(negedge clk);
    req_valid = vmask;
    rsp_ready = '0;
    #1;
    check({nm, ".accept_ready"}, 32'(req_ready), 32'(oh));
    check({nm, ".accept_rsp_valid"}, 32'(rsp_valid), 32'h0);
    @(negedge clk); #1;
    check({nm, ".exec_ready"}, 32'(req_ready), 32'h0);
    check({nm, ".exec_rsp_valid"}, 32'(rsp_valid), 32'h0);
    @(negedge clk); #1;
    check({nm, ".rsp_valid"}, 32'(rsp_valid), 32'(oh));
    check({nm, ".rsp_tag"}, 32'(rsp_tag), 32'(exp_tag));
    check({nm, ".resp_ready"}, 32'(req_ready), 32'h0);
    if (chk) begin
      check({nm, ".rsp_result"}, rsp_result, exp_res);
      check({nm, ".rsp_br_taken"}, 32'(rsp_br_taken), 32'(exp_br));
    end
    for (int s = 0; s < stall; s++) begin
      rsp_ready = ~oh;
      @(negedge clk); #1;
      check({nm, ".stall_rsp_valid"}, 32'(rsp_valid), 32'(oh));
      check({nm, ".stall_result"}, rsp_result, exp_res);
      check({nm, ".stall_ready"}, 32'(req_ready), 32'h0);
    end
    rsp_ready = oh;
  endtask

  task automatic go_idle(input string nm);
    @(negedge clk);
    req_valid = '0;
    rsp_ready = '0;
    #1;
    check({nm, ".idle_rsp_valid"}, 32'(rsp_valid), 32'h0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    req_valid = '0;
    rsp_ready = '0;
    rst_n     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] exp_stats;

    vecs[0] = '{2'b01, 0, ALU_ADD, 32'd5,         32'd7,         4'h3, 32'd12,        1'b0, 1'b1, 0};
    vecs[1] = '{2'b10, 1, ALU_BEQ, 32'h10,        32'h10,        4'h5, 32'd0,         1'b1, 1'b1, 0};
    vecs[2] = '{2'b10, 1, ALU_BNE, 32'h10,        32'h10,        4'h6, 32'd0,         1'b0, 1'b1, 0};
    vecs[3] = '{2'b11, 0, ALU_SUB, 32'd3,         32'd5,         4'h7, 32'hFFFF_FFFE, 1'b0, 1'b1, 5};
    vecs[4] = '{2'b10, 1, ALU_ADD, 32'hFFFF_FFFF, 32'd1,         4'h9, 32'd0,         1'b0, 1'b1, 0};
    vecs[5] = '{2'b01, 0, ALU_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 4'hC, 32'h00F0_1200, 1'b0, 1'b1, 0};
    vecs[6] = '{2'b10, 1, ALU_BAD, 32'd1,         32'd2,         4'hA, 32'd0,         1'b0, 1'b0, 0};

    rst_n       = 1'b0;
    req_valid   = '0;
    rsp_ready   = '0;
    req_alucode = '0;
    req_op1     = '0;
    req_op2     = '0;
    req_tag     = '0;
    #12;
    check("reset.req_ready", 32'(req_ready), 32'h0);
    check("reset.rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset.rsp_result", rsp_result, 32'h0);
    check("reset.rsp_br_taken", 32'(rsp_br_taken), 32'h0);
    check("reset.rsp_tag", 32'(rsp_tag), 32'h0);
    check("reset.alu_alucode", 32'(alu_alucode), 32'h0);
    check("reset.alu_op1", alu_op1, 32'h0);
    check("reset.alu_op2", alu_op2, 32'h0);
    check("reset.stat_grants", stat_grants, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      set_req(vecs[i].req, vecs[i].code, vecs[i].op1, vecs[i].op2, vecs[i].tag);
      do_txn($sformatf("vec%0d", i), vecs[i].vmask, vecs[i].req, vecs[i].exp_res,
             vecs[i].exp_br, vecs[i].tag, vecs[i].chk, vecs[i].stall);
    end
    go_idle("vec_end");

    // Both requesters held valid after reset: strict alternation starting at 0.
    apply_reset();
    set_req(0, ALU_ADD, 32'd1, 32'd1, 4'h1);
    set_req(1, ALU_ADD, 32'd2, 32'd2, 4'h2);
    for (int k = 0; k < 4; k++) begin
      do_txn($sformatf("rr%0d", k), 2'b11, k % 2, (k % 2 != 0) ? 32'd4 : 32'd2, 1'b0,
             (k % 2 != 0) ? 4'h2 : 4'h1, 1'b1, 0);
    end
    go_idle("rr_end");

    // req0 granted last (pointer at 0), then reset lands in EXEC.
    do_txn("pre_rst", 2'b01, 0, 32'd2, 1'b0, 4'h1, 1'b1, 0);
    @(negedge clk);
    req_valid = 2'b01;
    rsp_ready = '0;
    #1;
    check("rst_exec.accept_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    #2;
    rst_n     = 1'b0;
    req_valid = '0;
    #1;
    check("rst_exec.rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_exec.alu_op1", alu_op1, 32'h0);
    check("rst_exec.rsp_tag", 32'(rsp_tag), 32'h0);
    check("rst_exec.stat_grants", stat_grants, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      check("rst_exec.no_response", 32'(rsp_valid), 32'h0);
    end

    set_req(0, ALU_ADD, 32'd100, 32'd23, 4'h4);
    set_req(1, ALU_SUB, 32'd50,  32'd8,  4'h8);
    do_txn("post_both", 2'b11, 0, 32'd123, 1'b0, 4'h4, 1'b1, 0);
    do_txn("post_req1", 2'b10, 1, 32'd42,  1'b0, 4'h8, 1'b1, 0);
    do_txn("post_req0a", 2'b01, 0, 32'd123, 1'b0, 4'h4, 1'b1, 0);
    do_txn("post_req0b", 2'b01, 0, 32'd123, 1'b0, 4'h4, 1'b1, 0);
    go_idle("post_end");

`ifdef ALU_ARB_STATS_EN
    exp_stats = {16'd1, 16'd3};
`else
    exp_stats = 32'h0;
`endif
    check("stat_grants", stat_grants, exp_stats);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
